// File: rtl/scsi_port_responder.sv
// Host-side port of a SCSI controller: register file, 24-bit transfer counter
// and byte FIFO answering CS_/RE/WE/DACK strobes with DREQ_ and INTRQ.
module scsi_port_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int TC_W       = 24
) (
    input  logic       CPUCLK,
    input  logic       RESET_,
    input  logic       CS_,
    input  logic       A0,
    input  logic       RE,
    input  logic       WE,
    input  logic       DACK,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       DREQ_,
    output logic       INTRQ,
    input  logic [7:0] SD_I,
    input  logic       SD_IVALID,
    output logic       SD_IREADY,
    output logic [7:0] SD_O,
    output logic       SD_OVALID,
    input  logic       SD_OREADY
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [4:0] AR_CTRL = 5'h01;
    localparam logic [4:0] AR_TCH  = 5'h12;
    localparam logic [4:0] AR_TCM  = 5'h13;
    localparam logic [4:0] AR_TCL  = 5'h14;
    localparam logic [4:0] AR_STAT = 5'h17;
    localparam logic [4:0] AR_CMD  = 5'h18;

    localparam logic [7:0] STAT_DONE  = 8'h16;
    localparam logic [7:0] STAT_ABORT = 8'h21;
    localparam logic [7:0] CMD_START  = 8'h20;
    localparam logic [7:0] CMD_ABORT  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            re_q, re_d, we_q, we_d;
    logic            doe_q, doe_d;
    logic [7:0]      dout_q, dout_d;
    logic            dreq_n_q, dreq_n_d;
    logic            intrq_q, intrq_d;
    logic [4:0]      ar_q, ar_d;
    logic [TC_W-1:0] tc_q, tc_d;
    logic [TC_W-1:0] sc_q, sc_d;
    logic [7:0]      ctrl_q, ctrl_d;
    logic [7:0]      status_q, status_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic       re_rise, we_rise, dma_rd, dma_wr, reg_rd, reg_wr;
    logic       busy, dir, empty, full, dreq_cond;
    logic       sd_ireq, sd_push, sd_ovalid, sd_pop, rd_ok, wr_ok;
    logic       push, pop, fifo_clr, set_irq, clr_irq;
    logic [7:0] push_data, head, rdata, aux;
    logic [23:0] tc_b;

    // DREQ condition evaluated on any (state, control, occupancy) triple
    function automatic logic dreq_fn(input state_e st, input logic [7:0] ctrl,
                                     input logic [CW-1:0] cnt);
        return (st == ST_XFER) && ctrl[7] && (ctrl[0] ? (cnt != '0) : (cnt != FULL_CNT));
    endfunction

    assign re_rise   = RE & ~re_q;
    assign we_rise   = WE & ~we_q;
    assign dma_rd    = DACK & re_rise;
    assign dma_wr    = DACK & we_rise;
    assign reg_rd    = ~CS_ & ~DACK & re_rise;
    assign reg_wr    = ~CS_ & ~DACK & we_rise;

    assign busy      = (state_q != ST_IDLE);
    assign dir       = ctrl_q[0];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_CNT);
    assign dreq_cond = dreq_fn(state_q, ctrl_q, cnt_q);
    assign head      = mem_q[rd_ptr_q];

    assign sd_ireq   = (state_q == ST_XFER) & dir & ~full & (sc_q != '0);
    assign sd_push   = sd_ireq & SD_IVALID;
    assign sd_ovalid = busy & ~dir & ~empty;
    assign sd_pop    = sd_ovalid & SD_OREADY;
    assign rd_ok     = dma_rd & dreq_cond;
    // A host write into a full FIFO still lands when the sink pops in the same cycle
    assign wr_ok     = dma_wr & (state_q == ST_XFER) & ctrl_q[7] & ~dir & (~full | sd_pop);
    assign push      = sd_push | wr_ok;
    assign pop       = rd_ok | sd_pop;
    assign push_data = dir ? SD_I : DIN;
    assign aux       = {intrq_q, 2'b00, busy, 3'b000, dreq_cond};

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        tc_d     = tc_q;
        sc_d     = sc_q;
        ctrl_d   = ctrl_q;
        status_d = status_q;
        dout_d   = dout_q;
        re_d     = RE;
        we_d     = WE;
        doe_d    = RE & (DACK | ~CS_);
        set_irq  = 1'b0;
        clr_irq  = 1'b0;
        fifo_clr = 1'b0;
        tc_b     = 24'(tc_q);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        case (ar_q)
            AR_CTRL: rdata = ctrl_q;
            AR_TCH:  rdata = tc_b[23:16];
            AR_TCM:  rdata = tc_b[15:8];
            AR_TCL:  rdata = tc_b[7:0];
            AR_STAT: rdata = status_q;
            default: rdata = 8'h00;
        endcase

        if (state_q == ST_FLUSH && cnt_q == CW'(sd_pop)) begin
            state_d  = ST_IDLE;
            status_d = STAT_DONE;
            set_irq  = 1'b1;
        end

        if (dma_rd) begin
            dout_d = rd_ok ? head : 8'hFF;
        end
        if (rd_ok || wr_ok) begin
            tc_d = tc_q - TC_W'(1);
            if (tc_q == TC_W'(1)) begin
                if (rd_ok) begin
                    state_d  = ST_IDLE;
                    status_d = STAT_DONE;
                    set_irq  = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
        end
        if (sd_push) begin
            sc_d = sc_q - TC_W'(1);
        end

        if (reg_rd) begin
            if (!A0) begin
                dout_d = aux;
            end else begin
                dout_d = rdata;
                if (ar_q == AR_STAT) clr_irq = 1'b1;
                if (ar_q != AR_CMD) ar_d = ar_q + 5'd1;
            end
        end

        if (reg_wr) begin
            if (!A0) begin
                ar_d = DIN[4:0];
            end else begin
                if (ar_q != AR_CMD) ar_d = ar_q + 5'd1;
                case (ar_q)
                    AR_CTRL: if (!busy) ctrl_d = DIN;
                    AR_TCH:  if (!busy) begin tc_b[23:16] = DIN; tc_d = TC_W'(tc_b); end
                    AR_TCM:  if (!busy) begin tc_b[15:8]  = DIN; tc_d = TC_W'(tc_b); end
                    AR_TCL:  if (!busy) begin tc_b[7:0]   = DIN; tc_d = TC_W'(tc_b); end
                    AR_CMD: begin
                        if (DIN == CMD_START && !busy) begin
                            if (tc_q != '0) begin
                                state_d  = ST_XFER;
                                fifo_clr = 1'b1;
                                sc_d     = tc_q;
                            end else begin
                                status_d = STAT_DONE;
                                set_irq  = 1'b1;
                            end
                        end else if (DIN == CMD_ABORT && busy) begin
                            state_d  = ST_IDLE;
                            fifo_clr = 1'b1;
                            status_d = STAT_ABORT;
                            set_irq  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        intrq_d = set_irq | (intrq_q & ~clr_irq);

        if (fifo_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        // DREQ_ is registered from the next-state view so it tracks the causing edge
        dreq_n_d = ~dreq_fn(state_d, ctrl_d, cnt_d);
    end

    always_ff @(posedge CPUCLK or negedge RESET_) begin
        if (!RESET_) begin
            state_q  <= ST_IDLE;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            doe_q    <= 1'b0;
            dout_q   <= 8'h00;
            dreq_n_q <= 1'b1;
            intrq_q  <= 1'b0;
            ar_q     <= '0;
            tc_q     <= '0;
            sc_q     <= '0;
            ctrl_q   <= '0;
            status_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            re_q     <= re_d;
            we_q     <= we_d;
            doe_q    <= doe_d;
            dout_q   <= dout_d;
            dreq_n_q <= dreq_n_d;
            intrq_q  <= intrq_d;
            ar_q     <= ar_d;
            tc_q     <= tc_d;
            sc_q     <= sc_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CPUCLK) begin
        if (push && !fifo_clr) mem_q[wr_ptr_q] <= push_data;
    end

    assign DOUT      = dout_q;
    assign DOE       = doe_q;
    assign DREQ_     = dreq_n_q;
    assign INTRQ     = intrq_q;
    assign SD_IREADY = sd_ireq;
    assign SD_OVALID = sd_ovalid;
    assign SD_O      = sd_ovalid ? head : 8'h00;
endmodule
